// File: rtl/baud_pkg.sv
// Shared constants and helpers for the fractional baud generator.
// Register map addresses, reset divisor and a divisor calculator for software/bench use.
package baud_pkg;

    localparam logic [1:0] BAUD_ADDR_DIV_LO = 2'd0;
    localparam logic [1:0] BAUD_ADDR_DIV_HI = 2'd1;
    localparam logic [1:0] BAUD_ADDR_FRAC   = 2'd2;

    // Legacy reset value: 50 MHz core, 9600 bps, 16x oversampling.
    localparam int BAUD_DEFAULT_DIV = 326;

    // Integer divisor for a clock/baud pair; the rx period is divisor+1 cycles.
    function automatic int baud_calc_div(input longint clk_hz, input longint baud,
                                         input longint oversample);
        longint step;
        step = baud * oversample;
        return int'((clk_hz + step / 2) / step) - 1;
    endfunction

endpackage

// File: rtl/baud_generator_frac_if.sv
// Register-write, resync and tick bundle between the bus/UART side and the baud generator.
// No backpressure: writes take effect on the strobe cycle, ticks are one-cycle pulses.
interface baud_generator_frac_if #(
    parameter int DIV_W = 16
);
    logic             en;
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             rx_resync;
    logic             rx_tick;
    logic             tx_tick;
    logic [DIV_W-1:0] div_q;
    logic             cfg_pending;

    modport master (
        output en, wr_en, wr_addr, wr_data, rx_resync,
        input  rx_tick, tx_tick, div_q, cfg_pending
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data, rx_resync,
        output rx_tick, tx_tick, div_q, cfg_pending
    );
endinterface

// File: rtl/baud_frac_accum.sv
// Fractional phase accumulator: advances by frac_i on each rx wrap, carry_o adds one cycle.
// Carry is combinational from the current accumulator; no backpressure.
module baud_frac_accum #(
    parameter int FRAC_W = 4,
    parameter int FW     = (FRAC_W > 0) ? FRAC_W : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          adv_i,
    input  logic [FW-1:0] frac_i,
    output logic          carry_o
);

    if (FRAC_W == 0) begin : g_none
        assign carry_o = 1'b0;
    end else begin : g_accum
        logic [FRAC_W-1:0] acc_q, acc_d;
        logic [FRAC_W:0]   sum;

        assign sum     = {1'b0, acc_q} + {1'b0, frac_i};
        assign carry_o = sum[FRAC_W];

        always_comb begin
            acc_d = acc_q;
            if (clr_i) begin
                acc_d = '0;
            end else if (adv_i) begin
                acc_d = sum[FRAC_W-1:0];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end
    end

endmodule

// File: rtl/baud_generator_frac.sv
// Integer+fractional baud generator: rx_tick every div+1(+carry) cycles, tx_tick every OVERSAMPLE rx_ticks.
// Ticks registered one cycle after the counter wrap; no backpressure, en low freezes the phase.
module baud_generator_frac
    import baud_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV
) (
    input  logic                   clk,
    input  logic                   rst,
    baud_generator_frac_if.slave   bus
);

    localparam int               FW      = (FRAC_W > 0) ? FRAC_W : 1;
    localparam int               TXW     = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [TXW-1:0]   TX_TOP  = TXW'(OVERSAMPLE - 1);

    logic [DIV_W-1:0] active_div_q, active_div_d;
    logic [7:0]       staged_lo_q, staged_lo_d;
    logic [FW-1:0]    active_frac_q, active_frac_d;
    logic [FW-1:0]    staged_frac_q, staged_frac_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [TXW-1:0]   tx_sub_q, tx_sub_d;
    logic             rx_tick_q, rx_tick_d;
    logic             tx_tick_q, tx_tick_d;
    logic             pending_q, pending_d;

    logic             commit;
    logic             wrap;
    logic             carry;
    logic [DIV_W:0]   reload_sum;
    logic [DIV_W-1:0] reload;

    assign commit = bus.wr_en && (bus.wr_addr == BAUD_ADDR_DIV_HI);
    assign wrap   = bus.en && !commit && !bus.rx_resync && (cnt_q == '0);

    // A carry on the largest divisor would overflow the counter, so it is dropped.
    assign reload_sum = {1'b0, active_div_q} + {{DIV_W{1'b0}}, carry};
    assign reload     = reload_sum[DIV_W] ? active_div_q : reload_sum[DIV_W-1:0];

    baud_frac_accum #(
        .FRAC_W (FRAC_W)
    ) u_accum (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (commit),
        .adv_i   (wrap),
        .frac_i  (active_frac_q),
        .carry_o (carry)
    );

    always_comb begin
        active_div_d  = active_div_q;
        staged_lo_d   = staged_lo_q;
        active_frac_d = active_frac_q;
        staged_frac_d = staged_frac_q;
        cnt_d         = cnt_q;
        tx_sub_d      = tx_sub_q;
        rx_tick_d     = 1'b0;
        tx_tick_d     = 1'b0;
        pending_d     = pending_q;

        if (bus.wr_en && (bus.wr_addr == BAUD_ADDR_DIV_LO)) begin
            staged_lo_d = bus.wr_data;
            pending_d   = 1'b1;
        end
        if (bus.wr_en && (bus.wr_addr == BAUD_ADDR_FRAC)) begin
            staged_frac_d = bus.wr_data[FW-1:0];
            pending_d     = 1'b1;
        end

        if (commit) begin
            active_div_d  = {bus.wr_data[DIV_W-9:0], staged_lo_q};
            active_frac_d = staged_frac_q;
            cnt_d         = {bus.wr_data[DIV_W-9:0], staged_lo_q};
            tx_sub_d      = TX_TOP;
            pending_d     = 1'b0;
        end else if (bus.rx_resync) begin
            // Land mid-bit: half a period to the next oversample tick, tx phase untouched.
            cnt_d = active_div_q >> 1;
        end else if (bus.en) begin
            if (!wrap) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                cnt_d     = reload;
                rx_tick_d = 1'b1;
                if (tx_sub_q == '0) begin
                    tx_tick_d = 1'b1;
                    tx_sub_d  = TX_TOP;
                end else begin
                    tx_sub_d = tx_sub_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_div_q  <= DEF_DIV;
            staged_lo_q   <= DEF_DIV[7:0];
            active_frac_q <= '0;
            staged_frac_q <= '0;
            cnt_q         <= DEF_DIV;
            tx_sub_q      <= TX_TOP;
            rx_tick_q     <= 1'b0;
            tx_tick_q     <= 1'b0;
            pending_q     <= 1'b0;
        end else begin
            active_div_q  <= active_div_d;
            staged_lo_q   <= staged_lo_d;
            active_frac_q <= active_frac_d;
            staged_frac_q <= staged_frac_d;
            cnt_q         <= cnt_d;
            tx_sub_q      <= tx_sub_d;
            rx_tick_q     <= rx_tick_d;
            tx_tick_q     <= tx_tick_d;
            pending_q     <= pending_d;
        end
    end

    assign bus.rx_tick     = rx_tick_q;
    assign bus.tx_tick     = tx_tick_q;
    assign bus.div_q       = active_div_q;
    assign bus.cfg_pending = pending_q;

endmodule

// File: tb/tb_baud_generator_frac.sv
// Bench for baud_generator_frac: directed timing sequences, a vector table and a randomized run
// checked every cycle against a tick-schedule model.
module tb_baud_generator_frac;
    import baud_pkg::*;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OS     = 16;
    localparam int DEF    = 326;
    localparam int MAXDIV = (1 << DIV_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    baud_generator_frac_if #(.DIV_W(DIV_W)) bus ();

    baud_generator_frac #(
        .DIV_W       (DIV_W),
        .FRAC_W      (FRAC_W),
        .OVERSAMPLE  (OS),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: time remaining to the next visible rx_tick, plus the wrap count since the last commit.
    // The fractional carry of wrap k is floor(k*f/2^F) - floor((k-1)*f/2^F).
    bit     m_ok = 1'b0;
    int     m_div, m_frac, m_slo, m_sfrac, m_rem;
    bit     m_pend, m_rx, m_tx;
    longint m_k;

    function automatic int frac_carry(input longint k, input int f);
        return int'(((k * f) >>> FRAC_W) - (((k - 1) * f) >>> FRAC_W));
    endfunction

    task automatic model_step();
        int c;
        m_rx = 1'b0;
        m_tx = 1'b0;
        if (rst) begin
            m_ok = 1'b1; m_div = DEF; m_frac = 0; m_slo = DEF % 256; m_sfrac = 0;
            m_pend = 1'b0; m_rem = DEF + 1; m_k = 0;
        end else if (m_ok) begin
            if (bus.wr_en && bus.wr_addr == 2'd0) begin
                m_slo = int'(bus.wr_data); m_pend = 1'b1;
            end
            if (bus.wr_en && bus.wr_addr == 2'd2) begin
                m_sfrac = int'(bus.wr_data) % (1 << FRAC_W); m_pend = 1'b1;
            end
            if (bus.wr_en && bus.wr_addr == 2'd1) begin
                m_div = int'(bus.wr_data) * 256 + m_slo; m_frac = m_sfrac; m_pend = 1'b0;
                m_rem = m_div + 1; m_k = 0;
            end else if (bus.rx_resync) begin
                m_rem = m_div / 2 + 1;
            end else if (bus.en) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_k++;
                    m_rx = 1'b1;
                    m_tx = (m_k % OS) == 0;
                    c = (m_div == MAXDIV) ? 0 : frac_carry(m_k, m_frac);
                    m_rem = m_div + 1 + c;
                end
            end
        end
    endtask

    task automatic cycle();
        logic [63:0] act, exp;
        @(posedge clk);
        #1;
        model_step();
        if (m_ok) begin
            act = {45'd0, bus.rx_tick, bus.tx_tick, bus.cfg_pending, bus.div_q};
            exp = {45'd0, m_rx, m_tx, m_pend, m_div[15:0]};
            check("model", act, exp);
        end
    endtask

    task automatic write(input logic [1:0] addr, input logic [7:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        cycle();
        bus.wr_en = 1'b0;
    endtask

    // Edges until rx_tick is seen; -1 if the budget runs out.
    task automatic run_until_rx(input int budget, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!bus.rx_tick && n < budget);
        if (!bus.rx_tick) n = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx"},      64'(bus.rx_tick), 64'd0);
        check({tag, "_tx"},      64'(bus.tx_tick), 64'd0);
        check({tag, "_div"},     64'(bus.div_q), 64'd326);
        check({tag, "_pending"}, 64'(bus.cfg_pending), 64'd0);
    endtask

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] frac;
        int         cycles;
        int         exp_rx;
        int         exp_tx;
        int         exp_div;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n, t, rxc, txc;

        vecs[0] = '{8'h03, 8'h00, 8'h08,   72, 16, 1,   3};
        vecs[1] = '{8'h00, 8'h00, 8'h00,   20, 20, 1,   0};
        vecs[2] = '{8'hA3, 8'h00, 8'h00, 1000,  6, 0, 163};
        vecs[3] = '{8'h01, 8'h00, 8'h00,   64, 32, 2,   1};
        vecs[4] = '{8'h04, 8'h00, 8'h0F,  100, 17, 1,   4};
        vecs[5] = '{8'h00, 8'h01, 8'h00,  600,  2, 0, 256};
        vecs[6] = '{8'h00, 8'h00, 8'h08,   24, 16, 1,   0};

        rst = 1'b1;
        bus.en = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 8'd0;
        bus.rx_resync = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        check_reset_outputs("reset");
        check("calc_div_helper", 64'(baud_calc_div(64'd1843200, 64'd115200, 64'd16)), 64'd0);

        // Default rate: first rx_tick at edge 327, first tx_tick with the 16th rx_tick at edge 5232.
        bus.en = 1'b1;
        run_until_rx(400, n);
        check("first_rx_edge", 64'(n), 64'd327);
        t = n; rxc = 1;
        while (!bus.tx_tick && t < 6000) begin
            cycle(); t++;
            if (bus.rx_tick) rxc++;
        end
        check("first_tx_edge", 64'(t), 64'd5232);
        check("rx_per_tx", 64'(rxc), 64'd16);

        // Staged low byte leaves the old rate running until the commit.
        write(2'd0, 8'hA3);
        check("pending_after_lo", 64'(bus.cfg_pending), 64'd1);
        run_until_rx(400, n);
        check("old_rate_kept", 64'(n), 64'd326);
        write(2'd1, 8'h00);
        check("commit_no_tick", 64'(bus.rx_tick), 64'd0);
        check("commit_pending", 64'(bus.cfg_pending), 64'd0);
        check("commit_div", 64'(bus.div_q), 64'd163);
        run_until_rx(300, n);
        check("new_period_1", 64'(n), 64'd164);
        run_until_rx(300, n);
        check("new_period_2", 64'(n), 64'd164);

        // Resync mid-count: half period to next tick, tx phase still 16 rx_ticks from commit.
        write(2'd0, 8'h46);
        write(2'd1, 8'h01);
        repeat (100) cycle();
        bus.rx_resync = 1'b1;
        cycle();
        bus.rx_resync = 1'b0;
        check("resync_no_tick", 64'(bus.rx_tick), 64'd0);
        run_until_rx(400, n);
        check("resync_to_tick", 64'(n), 64'd164);
        rxc = 1; t = 0;
        while (!bus.tx_tick && t < 6000) begin
            cycle(); t++;
            if (bus.rx_tick) rxc++;
        end
        check("resync_tx_phase", 64'(rxc), 64'd16);

        // Commit landing on the wrap cycle suppresses the tick and reloads the new divisor.
        write(2'd0, 8'd9);
        write(2'd1, 8'd0);
        run_until_rx(20, n);
        check("div9_period", 64'(n), 64'd10);
        write(2'd0, 8'd5);
        repeat (8) cycle();
        write(2'd1, 8'd0);
        check("wrap_commit_rx", 64'(bus.rx_tick), 64'd0);
        check("wrap_commit_tx", 64'(bus.tx_tick), 64'd0);
        check("wrap_commit_div", 64'(bus.div_q), 64'd5);
        run_until_rx(20, n);
        check("div5_period", 64'(n), 64'd6);

        // en low for 50 cycles freezes the phase.
        repeat (2) cycle();
        bus.en = 1'b0;
        rxc = 0;
        repeat (50) begin
            cycle();
            if (bus.rx_tick) rxc++;
        end
        check("en_low_no_ticks", 64'(rxc), 64'd0);
        bus.en = 1'b1;
        run_until_rx(20, n);
        check("en_resume_phase", 64'(n), 64'd4);

        // Reset mid-count discards the staged byte.
        write(2'd0, 8'h11);
        check("pending_before_rst", 64'(bus.cfg_pending), 64'd1);
        repeat (7) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset_outputs("midrst");
        run_until_rx(400, n);
        check("midrst_first_rx", 64'(n), 64'd327);

        foreach (vecs[i]) begin
            write(2'd2, vecs[i].frac);
            write(2'd0, vecs[i].lo);
            write(2'd1, vecs[i].hi);
            rxc = 0; txc = 0;
            repeat (vecs[i].cycles) begin
                cycle();
                if (bus.rx_tick) rxc++;
                if (bus.tx_tick) txc++;
            end
            check($sformatf("vec%0d_rx", i), 64'(rxc), 64'(vecs[i].exp_rx));
            check($sformatf("vec%0d_tx", i), 64'(txc), 64'(vecs[i].exp_tx));
            check($sformatf("vec%0d_div", i), 64'(bus.div_q), 64'(vecs[i].exp_div));
        end

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom % 400) == 0;
            bus.en        = ($urandom % 8) != 0;
            bus.rx_resync = ($urandom % 40) == 0;
            bus.wr_en     = ($urandom % 10) == 0;
            bus.wr_addr   = 2'($urandom % 4);
            case (bus.wr_addr)
                2'd0:    bus.wr_data = 8'($urandom_range(0, 20));
                2'd1:    bus.wr_data = (($urandom % 8) == 0) ? 8'd1 : 8'd0;
                default: bus.wr_data = 8'($urandom);
            endcase
            cycle();
        end
        rst = 1'b0; bus.en = 1'b0; bus.wr_en = 1'b0; bus.rx_resync = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
